// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the register write-back controller
//
// Purpose: default datapath/address widths and the write-queue entry layout.
// Ports:   none (package).
package wb_pkg;

    localparam int WB_W = 8;
    localparam int WB_A = 2;

    // One pending register-file write. from_load marks entries whose pop
    // releases the destination's busy bit.
    typedef struct packed {
        logic [WB_A-1:0] addr;
        logic [WB_W-1:0] data;
        logic            from_load;
    } wq_entry_t;

    // Occupancy counters carry one extra bit so "full" is distinguishable.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - issue, load-return, decode and write-port bundle
//
// Purpose: groups every non-clock/reset signal of reg_writeback.
// Ports:   master = upstream/decode/regfile side, slave = reg_writeback.
//   issue:  iss_valid, iss_load, iss_dst, iss_data -> ; <- iss_ready
//   load:   ld_valid, ld_data ->                    ; <- ld_err
//   decode: src_a, src_b, src_a_use, src_b_use ->   ; <- hazard
//   write:  <- write_en, waddr, data_in
interface reg_writeback_if
    import wb_pkg::*;
#(
    parameter int W = WB_W,
    parameter int A = WB_A
);
    logic         iss_valid;
    logic         iss_load;
    logic [A-1:0] iss_dst;
    logic [W-1:0] iss_data;
    logic         iss_ready;
    logic         ld_valid;
    logic [W-1:0] ld_data;
    logic [A-1:0] src_a;
    logic [A-1:0] src_b;
    logic         src_a_use;
    logic         src_b_use;
    logic         hazard;
    logic         write_en;
    logic [A-1:0] waddr;
    logic [W-1:0] data_in;
    logic         ld_err;

    modport master (
        output iss_valid, iss_load, iss_dst, iss_data,
        output ld_valid, ld_data,
        output src_a, src_b, src_a_use, src_b_use,
        input  iss_ready, hazard, write_en, waddr, data_in, ld_err
    );

    modport slave (
        input  iss_valid, iss_load, iss_dst, iss_data,
        input  ld_valid, ld_data,
        input  src_a, src_b, src_a_use, src_b_use,
        output iss_ready, hazard, write_en, waddr, data_in, ld_err
    );
endinterface

// File: rtl/reg_writeback_dst_fifo.sv
// rtl/reg_writeback_dst_fifo.sv - small FIFO of register destinations
//
// Purpose: holds destinations of issued loads until their data returns.
// Ports:   clk, rst_n (async active-low), push/push_data, pop,
//          head (valid only when !empty), empty, full.
module dst_fifo
    import wb_pkg::*;
#(
    parameter int A     = WB_A,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [A-1:0] push_data,
    input  logic         pop,
    output logic [A-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [A-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_pop  = pop && !empty;
        // Push into a full FIFO is allowed only when the head leaves the same edge.
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - serialises ALU results and load returns into the register-file write port
//
// Purpose: write-side controller for the register file with a per-register
//          busy scoreboard for decode read-after-write stalls.
// Ports:   clk, rst_n (async active-low), bus (reg_writeback_if.slave):
//          issue handshake, load return, decode sources/hazard,
//          write port write_en/waddr/data_in, sticky ld_err.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int W        = WB_W,
    parameter int A        = WB_A,
    parameter int WQ_DEPTH = 4,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_writeback_if.slave  bus
);
    localparam int WQ_AW = $clog2(WQ_DEPTH);
    localparam int WQ_CW = WQ_AW + 1;
    localparam int NREG  = 2 ** A;

    // Write queue storage; only the slots between rd and rd+count are live.
    logic [A-1:0]     wq_addr [WQ_DEPTH];
    logic [W-1:0]     wq_data [WQ_DEPTH];
    logic             wq_ld   [WQ_DEPTH];
    logic [WQ_AW-1:0] wq_rd;
    logic [WQ_AW-1:0] wq_wr;
    logic [WQ_CW-1:0] wq_count;
    logic [WQ_CW-1:0] wq_free;

    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;
    logic [NREG-1:0]  pending;
    logic             ld_err_q;

    logic             lq_empty;
    logic             lq_full;
    logic [A-1:0]     lq_head;

    logic             accept;
    logic             alu_push;
    logic             lq_push;
    logic             ld_push;
    logic             ld_orphan;
    logic             wq_pop;
    logic [WQ_AW-1:0] alu_slot;

    dst_fifo #(
        .A     (A),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lq_push),
        .push_data (bus.iss_dst),
        .pop       (ld_push),
        .head      (lq_head),
        .empty     (lq_empty),
        .full      (lq_full)
    );

    // Issue acceptance and queue control. Two free WQ slots are demanded so a
    // same-cycle load return (which cannot stall) always has room too.
    always_comb begin
        wq_free       = WQ_CW'(WQ_DEPTH) - wq_count;
        bus.iss_ready = (wq_free >= WQ_CW'(2)) && !busy[bus.iss_dst] &&
                        (!bus.iss_load || !lq_full);
        accept        = bus.iss_valid && bus.iss_ready;
        alu_push      = accept && !bus.iss_load;
        lq_push       = accept && bus.iss_load;
        ld_push       = bus.ld_valid && !lq_empty;
        ld_orphan     = bus.ld_valid && lq_empty;
        wq_pop        = (wq_count != '0);
        // The load entry goes first; the ALU entry lands behind it when both push.
        alu_slot      = wq_wr + WQ_AW'(ld_push);
    end

    // Write port is the WQ head, forced to zero while idle so reset clears it.
    always_comb begin
        bus.write_en = wq_pop;
        bus.waddr    = wq_pop ? wq_addr[wq_rd] : '0;
        bus.data_in  = wq_pop ? wq_data[wq_rd] : '0;
        bus.ld_err   = ld_err_q;
    end

    // A register is pending while its load is outstanding or any queued write targets it.
    always_comb begin
        pending = busy;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if ({1'b0, WQ_AW'(WQ_AW'(i) - wq_rd)} < wq_count) begin
                pending[wq_addr[i]] = 1'b1;
            end
        end
        bus.hazard = (bus.src_a_use && pending[bus.src_a]) ||
                     (bus.src_b_use && pending[bus.src_b]);
    end

    always_comb begin
        busy_nxt = busy;
        if (wq_pop && wq_ld[wq_rd]) begin
            busy_nxt[wq_addr[wq_rd]] = 1'b0;
        end
        if (lq_push) begin
            busy_nxt[bus.iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_push) begin
            wq_addr[wq_wr] <= lq_head;
            wq_data[wq_wr] <= bus.ld_data;
            wq_ld[wq_wr]   <= 1'b1;
        end
        if (alu_push) begin
            wq_addr[alu_slot] <= bus.iss_dst;
            wq_data[alu_slot] <= bus.iss_data;
            wq_ld[alu_slot]   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq_rd    <= '0;
            wq_wr    <= '0;
            wq_count <= '0;
            busy     <= '0;
            ld_err_q <= 1'b0;
        end else begin
            wq_wr    <= wq_wr + WQ_AW'(ld_push) + WQ_AW'(alu_push);
            wq_rd    <= wq_rd + WQ_AW'(wq_pop);
            wq_count <= wq_count + WQ_CW'(ld_push) + WQ_CW'(alu_push) - WQ_CW'(wq_pop);
            busy     <= busy_nxt;
            if (ld_orphan) begin
                ld_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - self-checking bench for reg_writeback
module tb_reg_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_writeback_if #(.W(8), .A(2)) bus ();

    reg_writeback #(
        .W(8), .A(2), .WQ_DEPTH(4), .LQ_DEPTH(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        bit         ld;
    } ment_t;

    ment_t      m_wq[$];
    logic [1:0] m_lq[$];
    bit         m_busy[4];
    bit         m_err;

    int checks   = 0;
    int failures = 0;
    logic seen_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend(input logic [1:0] r);
        if (m_busy[r]) return 1'b1;
        foreach (m_wq[i]) if (m_wq[i].a == r) return 1'b1;
        return 1'b0;
    endfunction

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
    task automatic tick();
        bit         e_we, e_rdy, e_hz, acc;
        logic [1:0] e_wa;
        logic [7:0] e_di;
        ment_t      e;
        e_we  = (m_wq.size() != 0);
        e_wa  = e_we ? m_wq[0].a : 2'd0;
        e_di  = e_we ? m_wq[0].d : 8'd0;
        e_rdy = (4 - m_wq.size() >= 2) && !m_busy[bus.iss_dst] &&
                (!bus.iss_load || m_lq.size() < 2);
        e_hz  = (bus.src_a_use && pend(bus.src_a)) || (bus.src_b_use && pend(bus.src_b));
        #3;
        chk("write_en", bus.write_en, e_we);
        chk("waddr", bus.waddr, e_wa);
        chk("data_in", bus.data_in, e_di);
        chk("iss_ready", bus.iss_ready, e_rdy);
        chk("hazard", bus.hazard, e_hz);
        chk("ld_err", bus.ld_err, m_err);
        seen_ready = bus.iss_ready;
        acc = bus.iss_valid && e_rdy;
        @(posedge clk);
        if (m_wq.size() != 0) begin
            e = m_wq.pop_front();
            if (e.ld) m_busy[e.a] = 1'b0;
        end
        if (bus.ld_valid) begin
            if (m_lq.size() != 0) m_wq.push_back('{m_lq.pop_front(), bus.ld_data, 1'b1});
            else m_err = 1'b1;
        end
        if (acc) begin
            if (bus.iss_load) begin
                m_lq.push_back(bus.iss_dst);
                m_busy[bus.iss_dst] = 1'b1;
            end else begin
                m_wq.push_back('{bus.iss_dst, bus.iss_data, 1'b0});
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.iss_valid = 0; bus.iss_load = 0; bus.iss_dst = 0; bus.iss_data = 0;
        bus.ld_valid = 0; bus.ld_data = 0;
        bus.src_a = 0; bus.src_b = 0; bus.src_a_use = 0; bus.src_b_use = 0;
    endtask

    task automatic issue(input bit ld, input logic [1:0] dst, input logic [7:0] d);
        bus.iss_valid = 1; bus.iss_load = ld; bus.iss_dst = dst; bus.iss_data = d;
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        #1;
        bus.src_a = 2'd1; bus.src_a_use = 1; bus.src_b = 2'd2; bus.src_b_use = 1;
        bus.iss_dst = 2'd1; bus.iss_load = 1; bus.iss_valid = 0;
        rst_n = 0;
        #1;
        chk("rst_write_en", bus.write_en, 1'b0);
        chk("rst_waddr", bus.waddr, 2'd0);
        chk("rst_data_in", bus.data_in, 8'd0);
        chk("rst_ld_err", bus.ld_err, 1'b0);
        chk("rst_hazard", bus.hazard, 1'b0);
        chk("rst_iss_ready", bus.iss_ready, 1'b1);
        m_wq.delete(); m_lq.delete(); m_err = 0;
        for (int i = 0; i < 4; i++) m_busy[i] = 0;
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    end

    initial begin
        int guard;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Plain ALU write to r2, visible on the port the following cycle.
        issue(0, 2'd2, 8'hA5); tick();
        bus.iss_valid = 0;
        #3;
        chk("alu_we", bus.write_en, 1'b1);
        chk("alu_waddr", bus.waddr, 2'd2);
        chk("alu_data", bus.data_in, 8'hA5);
        #(-3 + 3);
        @(posedge clk); #1;
        m_wq.delete();
        tick();

        // Load to r1 with decode reading r1: hazard until the write is performed.
        bus.src_a = 2'd1; bus.src_a_use = 1;
        issue(1, 2'd1, 8'h00); tick();
        bus.iss_valid = 0; tick(); tick();
        bus.ld_valid = 1; bus.ld_data = 8'h3C; tick();
        bus.ld_valid = 0; tick(); tick();
        bus.src_a_use = 0;

        // WAW guard: ALU to r3 held off while a load to r3 is outstanding.
        issue(1, 2'd3, 8'h00); tick();
        issue(0, 2'd3, 8'h77); tick(); tick();
        bus.ld_valid = 1; bus.ld_data = 8'h5A; tick();
        bus.ld_valid = 0;
        guard = 0;
        seen_ready = 0;
        while (!seen_ready && guard < 10) begin tick(); guard++; end
        chk("waw_accept_within_bound", seen_ready, 1'b1);
        bus.iss_valid = 0; tick(); tick(); tick();

        // Simultaneous load return (r0) and ALU issue (r1): load written first.
        issue(1, 2'd0, 8'h00); tick();
        issue(0, 2'd1, 8'h22); bus.ld_valid = 1; bus.ld_data = 8'h11; tick();
        bus.iss_valid = 0; bus.ld_valid = 0; tick(); tick(); tick();

        // Fill the load queue, then a third load must be refused.
        issue(1, 2'd2, 8'h00); tick();
        issue(1, 2'd3, 8'h00); tick();
        issue(1, 2'd0, 8'h00); tick(); tick();
        bus.iss_valid = 0;
        bus.ld_valid = 1; bus.ld_data = 8'hC1; tick();
        bus.ld_data = 8'hC2; tick();
        bus.ld_valid = 0; tick(); tick(); tick();

        // Load return with nothing outstanding: dropped and flagged.
        bus.ld_valid = 1; bus.ld_data = 8'hEE; tick();
        bus.ld_valid = 0; tick(); tick();

        // Randomised traffic against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.iss_valid = ($urandom_range(0, 3) != 0);
            bus.iss_load  = ($urandom_range(0, 2) == 0);
            bus.iss_dst   = 2'($urandom_range(0, 3));
            bus.iss_data  = 8'($urandom);
            bus.ld_valid  = (m_lq.size() != 0) && ($urandom_range(0, 2) != 0);
            bus.ld_data   = 8'($urandom);
            bus.src_a     = 2'($urandom_range(0, 3));
            bus.src_b     = 2'($urandom_range(0, 3));
            bus.src_a_use = $urandom_range(0, 1);
            bus.src_b_use = $urandom_range(0, 1);
            tick();
        end

        // Reset mid-burst, then a stale load return must set ld_err.
        idle_inputs();
        issue(1, 2'd1, 8'h00); tick();
        issue(0, 2'd2, 8'h44); tick();
        issue(0, 2'd3, 8'h55); tick();
        do_reset();
        bus.ld_valid = 1; bus.ld_data = 8'h99; tick();
        bus.ld_valid = 0; tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
